shift_rows_pipe: RTL and testbench
==================================

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 Parameter NB, default 4: state columns; legal values 4, 6, 8; any other value SHALL be an elaboration error.
REQ-002 Parameter W = 32*NB, derived and not overridable: state width in bits.
REQ-003 Port clk, input, 1: single clock; all flops SHALL be rising-edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: state_in and inv carry a beat.
REQ-006 Port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 Port inv, input, 1: 0 selects forward ShiftRows; 1 selects InvShiftRows; sampled with the beat.
REQ-008 Port state_in, input, W: input state.
REQ-009 Port out_valid, output, 1: state_out holds a result.
REQ-010 Port out_ready, input, 1: downstream accepts the result.
REQ-011 Port state_out, output, W: permuted state.

Function
REQ-012 Byte (r,c), with r in 0..3 and c in 0..NB-1, SHALL occupy bits [W-1-8*(4c+r) -: 8] (byte 0 at the MSB, column-major).
REQ-013 Row offsets C_r SHALL be (0,1,2,3) for NB=4 and NB=6, and (0,1,3,4) for NB=8.
REQ-014 Forward mode SHALL produce out(r,c) = in(r,(c+C_r) mod NB).
REQ-015 Inverse mode SHALL produce out(r,c) = in(r,(c-C_r) mod NB).
REQ-016 A transfer occurs on a cycle with in_valid=1 and in_ready=1; the result SHALL appear with out_valid=1 on the next cycle (latency 1).
REQ-017 Once out_valid=1, state_out and out_valid SHALL hold stable until the cycle that has out_ready=1.
REQ-018 Beats SHALL leave in acceptance order; none dropped, none duplicated.
REQ-019 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-020 A simultaneous accept and drain on the same cycle SHALL replace the output with the new beat, with no bubble.
REQ-021 in_valid=1 while in_ready=0 SHALL have no effect; the source holds its data.
REQ-022 A change of inv between beats SHALL affect only beats accepted after the change.

Reset
REQ-023 Asserting rst SHALL immediately force out_valid=0, state_out=0, and all internal valid flags to 0, regardless of clk.
REQ-024 While rst=1, in_ready SHALL be 0.
REQ-025 in_ready SHALL be 1 on the first rising edge after rst deasserts.
REQ-026 Any beat in flight when rst asserts SHALL be discarded.

Configuration
REQ-027 Macro SHIFT_ROWS_SKID_EN defined: a two-entry skid buffer SHALL be built, and in_ready SHALL be a flop output with no combinational path from out_ready.
REQ-028 With SHIFT_ROWS_SKID_EN defined, in_ready SHALL fall only when both entries are full, and one skid beat SHALL be absorbed on the cycle out_ready falls.
REQ-029 Macro SHIFT_ROWS_SKID_EN absent: a single output register SHALL be built, with in_ready = !out_valid || out_ready (combinational).
REQ-030 REQ-012 through REQ-022 SHALL hold in both configurations.

Verification
REQ-031 NB=4, inv=0, state_in=000102030405060708090a0b0c0d0e0f -> next cycle state_out=00050a0f04090e03080d02070c01060b, out_valid=1.
REQ-032 NB=4, inv=1, state_in=00050a0f04090e03080d02070c01060b -> state_out=000102030405060708090a0b0c0d0e0f.
REQ-033 NB=8, inv=0, bytes 00..1f -> out(1,0)=05, out(2,0)=0e, out(3,0)=13; an inverse beat fed the result back returns 00..1f.
REQ-034 Ten back-to-back beats with alternating inv, out_ready=1 -> ten results on ten consecutive cycles, each correct for its own inv.
REQ-035 out_ready=0 for 5 cycles with in_valid=1 -> out held stable; no loss; order preserved; skid build accepts exactly 2 beats and no-skid build accepts exactly 1 before in_ready=0.
REQ-036 rst asserted mid-stream between clock edges -> out_valid=0 and state_out=0 at once; the first post-reset output is the first post-reset beat.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - AES ShiftRows/InvShiftRows stage with valid/ready handshake; optional skid buffer via SHIFT_ROWS_SKID_EN
module shift_rows_pipe #(
   parameter int  NB = 4,
   localparam int W  = 32*NB
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         inv,
   input  logic [W-1:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] state_out
);

   // Only the Rijndael block sizes have defined row offsets.
   generate
      if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
         $error("shift_rows_pipe: NB must be 4, 6 or 8");
      end
   endgenerate

   // Row shift amount; 256-bit blocks use a wider spread on rows 2 and 3.
   function automatic int row_off(input int r);
      if (NB == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   // Byte (r,c) lives at the MSB end, column-major; pure wiring permutation.
   function automatic logic [W-1:0] permute(input logic [W-1:0] s, input logic inv_mode);
      logic [W-1:0] res;
      int           src;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < NB; c++) begin
            if (inv_mode) src = (c - row_off(r) + NB) % NB;
            else          src = (c + row_off(r)) % NB;
            res[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src+r) -: 8];
         end
      end
      return res;
   endfunction

   logic [W-1:0] perm_in;
   assign perm_in = permute(state_in, inv);

`ifdef SHIFT_ROWS_SKID_EN
   logic         out_valid_q;
   logic [W-1:0] out_data_q;
   logic         skid_valid_q;
   logic [W-1:0] skid_data_q;
   logic         rdy_q;
   logic         accept;

   assign in_ready  = rdy_q;
   assign out_valid = out_valid_q;
   assign state_out = out_data_q;
   assign accept    = in_valid && rdy_q;

   // Output register plus one skid entry; ready is registered so the
   // upstream never sees a combinational path from out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         rdy_q        <= 1'b0;
      end else if (skid_valid_q) begin
         if (out_ready) begin
            out_data_q   <= skid_data_q;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b1;
         end else begin
            rdy_q        <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q || out_ready) begin
            out_valid_q <= 1'b1;
            out_data_q  <= perm_in;
            rdy_q       <= 1'b1;
         end else begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= perm_in;
            rdy_q        <= 1'b0;
         end
      end else begin
         if (out_ready) out_valid_q <= 1'b0;
         rdy_q <= 1'b1;
      end
   end
`else
   logic         out_valid_q;
   logic [W-1:0] out_data_q;

   assign in_ready  = !rst && (!out_valid_q || out_ready);
   assign out_valid = out_valid_q;
   assign state_out = out_data_q;

   // Single output register: refill on accept, empty on drain without refill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid_q <= 1'b1;
         out_data_q  <= perm_in;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - scoreboard testbench for shift_rows_pipe (NB=4 and NB=8 instances)
module tb_shift_rows_pipe;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, inv, out_valid, out_ready;
   logic [127:0] state_in, state_out;
   logic         in_valid8, in_ready8, inv8, out_valid8, out_ready8;
   logic [255:0] state_in8, state_out8;

   logic [127:0] sb [$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_rows_pipe #(.NB(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
      .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
   );

   shift_rows_pipe #(.NB(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .inv(inv8),
      .state_in(state_in8), .out_valid(out_valid8), .out_ready(out_ready8), .state_out(state_out8)
   );

   function automatic logic [255:0] model(input logic [255:0] s, input int nb, input logic iv);
      logic [7:0]   b [4][8];
      logic [255:0] o;
      int           off [4];
      int           w, src;
      w = 32*nb;
      off = (nb == 8) ? '{0, 1, 3, 4} : '{0, 1, 2, 3};
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            b[r][c] = s[w-1-8*(4*c+r) -: 8];
      o = '0;
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++) begin
            src = iv ? (c + nb - off[r]) % nb : (c + off[r]) % nb;
            o[w-1-8*(4*c+r) -: 8] = b[r][src];
         end
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drives one cycle from posedge+1, samples handshake at posedge+3, returns at next posedge+1.
   task automatic drive(input logic v, input logic iv, input logic [127:0] d, input logic ordy,
                        output logic acc, output logic drn, output logic [127:0] dout);
      logic [255:0] m;
      in_valid = v; inv = iv; state_in = d; out_ready = ordy;
      #2;
      acc  = in_valid && in_ready;
      drn  = out_valid && out_ready;
      dout = state_out;
      if (acc) begin
         m = model({128'b0, d}, 4, iv);
         sb.push_back(m[127:0]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; inv = 1'b0; state_in = '0; out_ready = 1'b1;
      in_valid8 = 1'b0; inv8 = 1'b0; state_in8 = '0; out_ready8 = 1'b1;
      #12;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (state_out !== '0) begin failures++; $display("FAIL reset_state_out got=%h exp=0", state_out); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid8 got=%b exp=0", out_valid8); end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_vectors();
      logic acc, drn;
      logic [127:0] dout;
      sb.delete();
      drive(1'b1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, acc, drn, dout);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fwd_vec_valid got=%b exp=1", out_valid); end
      checks++; if (state_out !== 128'h00050a0f04090e03080d02070c01060b) begin
         failures++; $display("FAIL fwd_vec got=%h exp=00050a0f04090e03080d02070c01060b", state_out); end
      drive(1'b1, 1'b1, 128'h00050a0f04090e03080d02070c01060b, 1'b1, acc, drn, dout);
      checks++; if (state_out !== 128'h000102030405060708090a0b0c0d0e0f) begin
         failures++; $display("FAIL inv_vec got=%h exp=000102030405060708090a0b0c0d0e0f", state_out); end
      drive(1'b0, 1'b0, '0, 1'b1, acc, drn, dout);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec_drained got=%b exp=0", out_valid); end
      sb.delete();
   endtask

   task automatic test_nb8();
      logic [255:0] orig;
      for (int k = 0; k < 32; k++) orig[255-8*k -: 8] = 8'(k);
      in_valid8 = 1'b1; inv8 = 1'b0; state_in8 = orig;
      #2;
      checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL nb8_ready got=%b exp=1", in_ready8); end
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      checks++; if (out_valid8 !== 1'b1) begin failures++; $display("FAIL nb8_valid got=%b exp=1", out_valid8); end
      checks++; if (state_out8[247 -: 8] !== 8'h05 || state_out8[239 -: 8] !== 8'h0e || state_out8[231 -: 8] !== 8'h13) begin
         failures++; $display("FAIL nb8_col0 got=%h exp=05_0e_13", state_out8[247:224]); end
      checks++; if (state_out8 !== model(orig, 8, 1'b0)) begin
         failures++; $display("FAIL nb8_fwd got=%h exp=%h", state_out8, model(orig, 8, 1'b0)); end
      in_valid8 = 1'b1; inv8 = 1'b1; state_in8 = state_out8;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      checks++; if (state_out8 !== orig) begin failures++; $display("FAIL nb8_roundtrip got=%h exp=%h", state_out8, orig); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic acc, drn;
      logic [127:0] dout, cur, exp;
      int sent, got, cyc, first_d, last_d, last_acc;
      sent = 0; got = 0; cyc = 0; first_d = -1; last_d = -1; last_acc = -1;
      sb.delete();
      cur = rnd128();
      while ((sent < 10 || got < 10) && cyc < 40) begin
         drive(sent < 10, sent[0], cur, 1'b1, acc, drn, dout);
         if (acc) begin sent++; last_acc = cyc; cur = rnd128(); end
         if (drn) begin
            got++; if (first_d < 0) first_d = cyc; last_d = cyc;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL b2b_extra got=%h exp=none", dout); end
            else begin
               exp = sb.pop_front();
               if (dout !== exp) begin failures++; $display("FAIL b2b_data got=%h exp=%h", dout, exp); end
            end
         end
         cyc++;
      end
      checks++; if (got !== 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", got); end
      checks++; if (last_d - first_d !== 9) begin failures++; $display("FAIL b2b_consecutive got=%0d exp=9", last_d - first_d); end
      checks++; if (last_acc !== 9) begin failures++; $display("FAIL b2b_accept_rate got=%0d exp=9", last_acc); end
   endtask

   task automatic test_backpressure();
      logic acc, drn;
      logic [127:0] dout, cur, exp, held;
      logic curinv;
      int sent, got, cyc, exp_acc;
`ifdef SHIFT_ROWS_SKID_EN
      exp_acc = 2;
`else
      exp_acc = 1;
`endif
      sent = 0; got = 0; cyc = 0;
      sb.delete();
      cur = rnd128(); curinv = 1'($urandom);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, curinv, cur, 1'b0, acc, drn, dout);
         if (acc) begin sent++; cur = rnd128(); curinv = 1'($urandom); end
         if (i == 0) held = state_out;
         else begin
            checks++;
            if (state_out !== held || out_valid !== 1'b1) begin
               failures++; $display("FAIL bp_hold got=%h/%b exp=%h/1", state_out, out_valid, held); end
         end
      end
      checks++; if (sent !== exp_acc) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", sent, exp_acc); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      while ((sent < 4 || sb.size() != 0) && cyc < 30) begin
         drive(sent < 4, curinv, cur, 1'b1, acc, drn, dout);
         if (acc) begin sent++; cur = rnd128(); curinv = 1'($urandom); end
         if (drn) begin
            got++; checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL bp_extra got=%h exp=none", dout); end
            else begin
               exp = sb.pop_front();
               if (dout !== exp) begin failures++; $display("FAIL bp_order got=%h exp=%h", dout, exp); end
            end
         end
         cyc++;
      end
      checks++; if (got !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
   endtask

   task automatic test_random();
      logic acc, drn;
      logic [127:0] dout, cur, exp;
      logic curinv, v;
      int cyc;
      cyc = 0;
      sb.delete();
      cur = rnd128(); curinv = 1'($urandom); v = 1'b0;
      while ((cyc < 80 || sb.size() != 0 || out_valid) && cyc < 200) begin
         if (!v) v = (cyc < 80) && ($urandom_range(0, 3) != 0);
         drive(v, curinv, cur, (cyc >= 80) || ($urandom_range(0, 2) != 0), acc, drn, dout);
         if (acc) begin v = 1'b0; cur = rnd128(); curinv = 1'($urandom); end
         if (drn) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL rnd_extra got=%h exp=none", dout); end
            else begin
               exp = sb.pop_front();
               if (dout !== exp) begin failures++; $display("FAIL rnd_data got=%h exp=%h", dout, exp); end
            end
         end
         cyc++;
      end
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_mid_reset();
      logic acc, drn;
      logic [127:0] dout, first, exp;
      int cyc, got;
      sb.delete();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rnd128(), 1'b0, acc, drn, dout);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      checks++; if (state_out !== '0) begin failures++; $display("FAIL midrst_state got=%h exp=0", state_out); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
      sb.delete();
      #1 rst = 1'b0;
      @(posedge clk); #1;
      first = rnd128(); cyc = 0; got = 0;
      while (got == 0 && cyc < 20) begin
         drive(sb.size() == 0 && cyc < 10, 1'b1, first, 1'b1, acc, drn, dout);
         if (drn) begin
            got++; checks++;
            exp = sb.pop_front();
            if (dout !== exp) begin failures++; $display("FAIL midrst_first got=%h exp=%h", dout, exp); end
         end
         cyc++;
      end
      checks++; if (got !== 1) begin failures++; $display("FAIL midrst_timeout got=%0d exp=1", got); end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_nb8();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
